// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: set-mode encoding, field limits
// and a small binary-to-BCD helper used to build counter constants.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_t;

  localparam int unsigned SEC_MAX   = 32'd59;
  localparam int unsigned MIN_MAX   = 32'd59;
  localparam int unsigned HR_MAX_24 = 32'd23;
  localparam int unsigned HR_MAX_12 = 32'd12;

  // Binary 0..99 to packed two-digit BCD {tens, ones}.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that steps MIN_VAL..MAX_VAL and wraps; load has priority
// over inc, and wrap pulses one cycle after an increment taken from MAX_VAL.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter int unsigned MIN_VAL   = 32'd0,
  parameter int unsigned MAX_VAL   = 32'd59,
  parameter int unsigned RESET_VAL = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_bcd,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       at_max,
  output logic       wrap
);

  localparam logic [7:0] MIN_BCD = bin2bcd(7'(MIN_VAL));
  localparam logic [7:0] MAX_BCD = bin2bcd(7'(MAX_VAL));
  localparam logic [7:0] RST_BCD = bin2bcd(7'(RESET_VAL));

  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic       wrap_r;
  logic [7:0] next_s;

  assign at_max = ({tens_r, ones_r} == MAX_BCD);

  // Next BCD value for an increment, wrapping back to the minimum.
  always_comb begin
    next_s = {tens_r, ones_r};
    if (at_max) begin
      next_s = MIN_BCD;
    end else if (ones_r == 4'd9) begin
      next_s = {tens_r + 4'd1, 4'd0};
    end else begin
      next_s = {tens_r, ones_r + 4'd1};
    end
  end

  // Digit registers and the registered wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      {tens_r, ones_r} <= RST_BCD;
      wrap_r           <= 1'b0;
    end else if (load) begin
      {tens_r, ones_r} <= load_bcd;
      wrap_r           <= 1'b0;
    end else if (inc) begin
      {tens_r, ones_r} <= next_s;
      wrap_r           <= at_max;
    end else begin
      wrap_r           <= 1'b0;
    end
  end

  assign tens = tens_r;
  assign ones = ones_r;
  assign wrap = wrap_r;

endmodule

// File: rtl/time_of_day_counter.sv
// Wall-clock HH:MM:SS in BCD driven by a one-second tick, with a button-driven
// set mode (hours, then minutes), edit blink flag and rollover pulses.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter bit          HOUR_24    = 1'b1,
  parameter int unsigned RESET_HOUR = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blink,
  output logic       min_carry,
  output logic       day_carry
);

  localparam int unsigned HR_MIN = HOUR_24 ? 32'd0 : 32'd1;
  localparam int unsigned HR_MAX = HOUR_24 ? HR_MAX_24 : HR_MAX_12;

  mode_t mode_r;
  logic  blink_r;
  logic  pm_r;
  logic  day_carry_r;

  logic  run_tick_s;
  logic  sec_max_s, min_max_s, hr_max_s;
  logic  sec_inc_s, min_inc_s, hr_inc_s;
  logic  sec_load_s;
  logic  hr_is_11_s;
  logic  pm_toggle_s;
  logic  day_carry_s;
  logic  min_wrap_s, hr_wrap_s;
  logic  unused_wrap_s;

  // A tick coinciding with mode_btn in RUN is dropped in favour of the transition.
  assign run_tick_s  = (mode_r == MODE_RUN) && tick && !mode_btn;
  assign sec_inc_s   = run_tick_s;
  assign min_inc_s   = (run_tick_s && sec_max_s) ||
                       ((mode_r == MODE_SET_MIN) && inc_btn && !mode_btn);
  assign hr_inc_s    = (run_tick_s && sec_max_s && min_max_s) ||
                       ((mode_r == MODE_SET_HR) && inc_btn && !mode_btn);
  assign sec_load_s  = (mode_r == MODE_SET_MIN) && mode_btn;
  assign hr_is_11_s  = (hr_tens == 4'd1) && (hr_ones == 4'd1);
  assign pm_toggle_s = !HOUR_24 && hr_inc_s && hr_is_11_s;
  // End of day: 23:59:59 in 24h, 11:59:59 pm in 12h.
  assign day_carry_s = run_tick_s && sec_max_s && min_max_s &&
                       (HOUR_24 ? hr_max_s : (hr_is_11_s && pm_r));
  assign unused_wrap_s = min_wrap_s | hr_wrap_s;

  bcd2_counter #(.MIN_VAL(32'd0), .MAX_VAL(SEC_MAX), .RESET_VAL(32'd0)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc_s), .load(sec_load_s), .load_bcd(8'h00),
    .tens(sec_tens), .ones(sec_ones), .at_max(sec_max_s), .wrap(min_carry)
  );

  bcd2_counter #(.MIN_VAL(32'd0), .MAX_VAL(MIN_MAX), .RESET_VAL(32'd0)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc_s), .load(1'b0), .load_bcd(8'h00),
    .tens(min_tens), .ones(min_ones), .at_max(min_max_s), .wrap(min_wrap_s)
  );

  bcd2_counter #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .RESET_VAL(RESET_HOUR)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc_s), .load(1'b0), .load_bcd(8'h00),
    .tens(hr_tens), .ones(hr_ones), .at_max(hr_max_s), .wrap(hr_wrap_s)
  );

  // Set-mode FSM, blink, pm flag and the end-of-day pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r      <= MODE_RUN;
      blink_r     <= 1'b0;
      pm_r        <= 1'b0;
      day_carry_r <= 1'b0;
    end else begin
      day_carry_r <= day_carry_s;
      if (pm_toggle_s) begin
        pm_r <= ~pm_r;
      end
      case (mode_r)
        MODE_RUN: begin
          blink_r <= 1'b0;
          if (mode_btn) begin
            mode_r <= MODE_SET_HR;
          end
        end
        MODE_SET_HR: begin
          if (tick) begin
            blink_r <= ~blink_r;
          end
          if (mode_btn) begin
            mode_r <= MODE_SET_MIN;
          end
        end
        MODE_SET_MIN: begin
          if (mode_btn) begin
            mode_r  <= MODE_RUN;
            blink_r <= 1'b0;
          end else if (tick) begin
            blink_r <= ~blink_r;
          end
        end
        default: begin
          mode_r  <= MODE_RUN;
          blink_r <= 1'b0;
        end
      endcase
    end
  end

  assign pm        = pm_r;
  assign mode      = mode_r;
  assign blink     = blink_r;
  assign day_carry = day_carry_r;

endmodule
